// File: rtl/dec_pkg.sv
// Shared types and constants for the one-hot decode / scan sequencer family.
package dec_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_scan_seq_if.sv
// Request/selection bundle between a requester (master) and dec_scan_seq (slave).
// err exists only when DEC_RANGE_ERR_EN is defined.
interface dec_scan_seq_if #(
  parameter int AW     = 5,
  parameter int NOUT   = 32,
  parameter int DWELLW = 8
);
  logic              en;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_addr;
  logic [DWELLW-1:0] dwell;
  logic              stop;
  logic [NOUT-1:0]   out;
  logic              out_valid;
  logic              busy;
  logic              scan_done;
  logic [AW-1:0]     cur_addr;
`ifdef DEC_RANGE_ERR_EN
  logic              err;
`endif

  modport master (
    output en, mode, in_valid, in_addr, dwell, stop,
    input  in_ready, out, out_valid, busy, scan_done, cur_addr
`ifdef DEC_RANGE_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  en, mode, in_valid, in_addr, dwell, stop,
    output in_ready, out, out_valid, busy, scan_done, cur_addr
`ifdef DEC_RANGE_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/onehot_dec.sv
// Combinational AW-to-NOUT one-hot decoder; addresses >= NOUT decode to zero.
module onehot_dec #(
  parameter int AW   = 5,
  parameter int NOUT = 32
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NOUT-1:0] onehot
);

  // Compare against every output index so out-of-range addresses yield all zeros.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NOUT; i++) begin
      if (en && (addr == AW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_scan_seq.sv
// Registered one-hot decoder with direct and dwell-timed scan modes.
// Optional macro DEC_RANGE_ERR_EN: adds err pulse and rejects out-of-range scans.
//
// state   | meaning
// ST_IDLE | direct selection held (or none); requests accepted
// ST_SCAN | walking 0..end, each address held dwell+1 enabled cycles
module dec_scan_seq
  import dec_pkg::*;
#(
  parameter int AW     = 5,
  parameter int NOUT   = 32,
  parameter int DWELLW = 8
) (
  input logic          clk,
  input logic          rst,
  dec_scan_seq_if.slave bus
);

  localparam logic [AW:0]   NOUT_W    = (AW+1)'(NOUT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NOUT - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cur_q, cur_d, end_q, end_d;
  logic [DWELLW-1:0] dwell_q, dwell_d, dcnt_q, dcnt_d;
  logic [NOUT-1:0]   out_q, dec_out;
  logic              out_valid_q, show_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept, in_range, scan_ok;

  assign in_range     = ({1'b0, bus.in_addr} < NOUT_W);
  assign bus.in_ready = (state_q == ST_IDLE) && bus.en && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef DEC_RANGE_ERR_EN
  logic err_q, err_d;
  assign scan_ok = in_range;
  assign bus.err = err_q;
`else
  assign scan_ok = 1'b1;
`endif

  // Next-state, counters and what the output register should show next cycle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    dwell_d = dwell_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    show_d  = 1'b0;
`ifdef DEC_RANGE_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        show_d = out_valid_q && bus.en;
        if (accept) begin
`ifdef DEC_RANGE_ERR_EN
          err_d = !in_range;
`endif
          case (bus.mode)
            MODE_DIRECT: begin
              show_d = in_range;
              if (in_range) cur_d = bus.in_addr;
            end
            MODE_SCAN: begin
              // A rejected scan leaves the held selection untouched.
              if (scan_ok) begin
                state_d = ST_SCAN;
                cur_d   = '0;
                end_d   = in_range ? bus.in_addr : LAST_ADDR;
                dwell_d = bus.dwell;
                dcnt_d  = bus.dwell;
                busy_d  = 1'b1;
                show_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SCAN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (!bus.en) begin
          busy_d = 1'b1;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DWELLW'(1);
          show_d = 1'b1;
        end else if (cur_q == end_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cur_d  = cur_q + AW'(1);
          dcnt_d = dwell_q;
          show_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  onehot_dec #(.AW(AW), .NOUT(NOUT)) u_dec (
    .addr  (cur_d),
    .en    (show_d),
    .onehot(dec_out)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      dwell_q     <= '0;
      dcnt_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DEC_RANGE_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      dwell_q     <= dwell_d;
      dcnt_q      <= dcnt_d;
      out_q       <= dec_out;
      out_valid_q <= show_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DEC_RANGE_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.scan_done = done_q;
  assign bus.cur_addr  = cur_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed + randomized bench for dec_scan_seq (NOUT=32 and NOUT=20 instances).
module tb_dec_scan_seq;
  localparam int AW = 5, NOUT = 32, DW = 8, N20 = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  dec_scan_seq_if #(.AW(AW), .NOUT(NOUT), .DWELLW(DW)) bus();
  dec_scan_seq_if #(.AW(AW), .NOUT(N20),  .DWELLW(DW)) bus20();

  dec_scan_seq #(.AW(AW), .NOUT(NOUT), .DWELLW(DW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  dec_scan_seq #(.AW(AW), .NOUT(N20), .DWELLW(DW)) u_dut20 (
    .clk(clk), .rst(rst), .bus(bus20.slave));

  always #5 clk = ~clk;

  // Expected select vector for address a on an n-output decoder.
  function automatic logic [63:0] sel(int a, int n);
    return (a >= 0 && a < n) ? (64'd1 << a) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic direct(int a);
    bus.mode     = 1'b0;
    bus.in_addr  = AW'(a);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic start_scan(int e, int dw);
    bus.mode     = 1'b1;
    bus.in_addr  = AW'(e);
    bus.dwell    = DW'(dw);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Expected walk: each address 0..min(end,NOUT-1) repeated dwell+1 times.
  // Returns positioned in the scan_done cycle.
  task automatic run_scan(int e_in, int dw, string tag);
    int q[$];
    int e;
    e = (e_in > NOUT - 1) ? NOUT - 1 : e_in;
    for (int a = 0; a <= e; a++)
      for (int k = 0; k <= dw; k++) q.push_back(a);
    start_scan(e_in, dw);
    foreach (q[i]) begin
      chk({tag, " out"},  64'(bus.out), sel(q[i], NOUT));
      chk({tag, " cur"},  64'(bus.cur_addr), 64'(q[i]));
      chk({tag, " busy"}, 64'(bus.busy), 64'd1);
      chk({tag, " done_early"}, 64'(bus.scan_done), 64'd0);
      tick();
    end
    chk({tag, " done"},     64'(bus.scan_done), 64'd1);
    chk({tag, " end_out"},  64'(bus.out), 64'd0);
    chk({tag, " end_oval"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " end_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " end_rdy"},  64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int a, e, dw;
    bus.en = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_addr = '0;
    bus.dwell = '0; bus.stop = 1'b0;
    bus20.en = 1'b0; bus20.mode = 1'b0; bus20.in_valid = 1'b0; bus20.in_addr = '0;
    bus20.dwell = '0; bus20.stop = 1'b0;
    tick(); tick();

    // reset state
    chk("rst out",  64'(bus.out), 64'd0);
    chk("rst oval", 64'(bus.out_valid), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.scan_done), 64'd0);
    chk("rst cur",  64'(bus.cur_addr), 64'd0);
    chk("rst rdy",  64'(bus.in_ready), 64'd0);
    rst = 1'b0; bus.en = 1'b1; bus20.en = 1'b1;
    #1;
    chk("rdy after rst", 64'(bus.in_ready), 64'd1);

    // 1: direct decode
    direct(5);
    chk("t1 out",  64'(bus.out), 64'h20);
    chk("t1 oval", 64'(bus.out_valid), 64'd1);
    chk("t1 cur",  64'(bus.cur_addr), 64'd5);
    chk("t1 rdy",  64'(bus.in_ready), 64'd1);
    tick();
    chk("t1 hold", 64'(bus.out), 64'h20);

    // stop in IDLE has no effect
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("idle stop out",  64'(bus.out), 64'h20);
    chk("idle stop oval", 64'(bus.out_valid), 64'd1);

    // en=0 drops direct selection; it does not come back
    bus.en = 1'b0; tick();
    chk("en0 out",  64'(bus.out), 64'd0);
    chk("en0 oval", 64'(bus.out_valid), 64'd0);
    chk("en0 rdy",  64'(bus.in_ready), 64'd0);
    bus.mode = 1'b0; bus.in_addr = AW'(7); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.en = 1'b1;
    tick();
    chk("en1 lost oval", 64'(bus.out_valid), 64'd0);
    chk("not queued out", 64'(bus.out), 64'd0);

    // 2: scan end=3 dwell=1, then accept in the scan_done cycle
    run_scan(3, 1, "t2");
    direct(9);
    chk("t2 back2back out",  64'(bus.out), 64'h200);
    chk("t2 done cleared",   64'(bus.scan_done), 64'd0);

    // 3: stop mid-scan
    start_scan(7, 0);
    chk("t3 cur0", 64'(bus.cur_addr), 64'd0);
    tick();
    chk("t3 cur1", 64'(bus.cur_addr), 64'd1);
    tick();
    chk("t3 cur2", 64'(bus.cur_addr), 64'd2);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("t3 out",  64'(bus.out), 64'd0);
    chk("t3 oval", 64'(bus.out_valid), 64'd0);
    chk("t3 busy", 64'(bus.busy), 64'd0);
    chk("t3 done", 64'(bus.scan_done), 64'd0);
    tick();
    chk("t3 done later", 64'(bus.scan_done), 64'd0);

    // stop on the final dwell cycle wins over completion
    start_scan(0, 0);
    chk("lastcyc out", 64'(bus.out), 64'h1);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("lastcyc done", 64'(bus.scan_done), 64'd0);
    chk("lastcyc busy", 64'(bus.busy), 64'd0);

    // 4: en gap during second cycle of addr 1 (end=3, dwell=3)
    start_scan(3, 3);
    for (int k = 0; k < 4; k++) begin
      chk("t4 a0", 64'(bus.out), 64'h1);
      tick();
    end
    chk("t4 a1 c1", 64'(bus.out), 64'h2);
    tick();
    chk("t4 a1 c2", 64'(bus.out), 64'h2);
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4 gap out",  64'(bus.out), 64'd0);
      chk("t4 gap busy", 64'(bus.busy), 64'd1);
      chk("t4 gap cur",  64'(bus.cur_addr), 64'd1);
    end
    bus.en = 1'b1;
    tick();
    chk("t4 a1 c3", 64'(bus.out), 64'h2);
    tick();
    chk("t4 a1 c4", 64'(bus.out), 64'h2);
    tick();
    chk("t4 a2", 64'(bus.out), 64'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4 a2", 64'(bus.out), 64'h4);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4 a3", 64'(bus.out), 64'h8);
    end
    tick();
    chk("t4 done", 64'(bus.scan_done), 64'd1);
    tick();
    chk("t4 done pulse", 64'(bus.scan_done), 64'd0);

    // 5: NOUT=20 instance, out-of-range address
    bus20.mode = 1'b0; bus20.in_addr = AW'(3); bus20.in_valid = 1'b1;
    tick(); bus20.in_valid = 1'b0;
    chk("t5 sel3", 64'(bus20.out), 64'h8);
    bus20.in_addr = AW'(25); bus20.in_valid = 1'b1;
    tick(); bus20.in_valid = 1'b0;
    chk("t5 oor out",  64'(bus20.out), 64'd0);
    chk("t5 oor oval", 64'(bus20.out_valid), 64'd0);
    chk("t5 oor cur",  64'(bus20.cur_addr), 64'd3);
`ifdef DEC_RANGE_ERR_EN
    chk("t5 err", 64'(bus20.err), 64'd1);
    tick();
    chk("t5 err pulse", 64'(bus20.err), 64'd0);
    bus20.in_addr = AW'(3); bus20.in_valid = 1'b1;
    tick(); bus20.in_valid = 1'b0;
    chk("t5 err0 direct", 64'(bus20.err), 64'd0);
    bus20.mode = 1'b1; bus20.in_addr = AW'(25); bus20.in_valid = 1'b1;
    tick(); bus20.in_valid = 1'b0;
    chk("t5 scan rej busy", 64'(bus20.busy), 64'd0);
    chk("t5 scan rej out",  64'(bus20.out), 64'h8);
    chk("t5 scan rej err",  64'(bus20.err), 64'd1);
`else
    bus20.mode = 1'b1; bus20.in_addr = AW'(25); bus20.dwell = '0; bus20.in_valid = 1'b1;
    tick(); bus20.in_valid = 1'b0;
    for (int k = 0; k < N20; k++) begin
      chk("t5 clamp out",  64'(bus20.out), sel(k, N20));
      chk("t5 clamp busy", 64'(bus20.busy), 64'd1);
      tick();
    end
    chk("t5 clamp done", 64'(bus20.scan_done), 64'd1);
    chk("t5 clamp end",  64'(bus20.out), 64'd0);
`endif

    // 6: reset mid-scan
    tick();
    start_scan(7, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t6 cur4", 64'(bus.cur_addr), 64'd4);
    rst = 1'b1; tick();
    chk("t6 out",  64'(bus.out), 64'd0);
    chk("t6 oval", 64'(bus.out_valid), 64'd0);
    chk("t6 busy", 64'(bus.busy), 64'd0);
    chk("t6 done", 64'(bus.scan_done), 64'd0);
    chk("t6 cur",  64'(bus.cur_addr), 64'd0);
    chk("t6 rdy in rst", 64'(bus.in_ready), 64'd0);
    rst = 1'b0; #1;
    chk("t6 rdy", 64'(bus.in_ready), 64'd1);
    direct(0);
    chk("t6 out0", 64'(bus.out), 64'h1);

    // randomized transactions against the walk model
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = int'($urandom_range(0, NOUT - 1));
        direct(a);
        chk("rnd dir out",  64'(bus.out), sel(a, NOUT));
        chk("rnd dir cur",  64'(bus.cur_addr), 64'(a));
        chk("rnd dir oval", 64'(bus.out_valid), 64'd1);
      end else begin
        e  = int'($urandom_range(0, NOUT - 1));
        dw = int'($urandom_range(0, 3));
        run_scan(e, dw, "rnd scan");
        tick();
        chk("rnd done pulse", 64'(bus.scan_done), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec_scan_seq.md
Name: dec_scan_seq

Overview:
- Parametrised, registered N-to-NOUT one-hot decoder with a valid/ready input handshake.
- Two modes:
  - Direct: decode one address and hold it.
  - Scan: walk outputs 0..end_addr, holding each address for a programmable dwell.
- Next generation of the combinational 3-to-8 / 5-to-32 decoders; drives row/channel selects for display and peripheral strobing.

Parameters:
- AW, 5, address width.
- NOUT, 32, number of one-hot outputs; 2 <= NOUT <= 2**AW.
- DWELLW, 8, width of the dwell count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable.
- mode  in  1  0 = direct, 1 = scan; sampled on accept.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted.
- in_addr  in  AW  direct address, or scan end address.
- dwell  in  DWELLW  extra hold cycles per scan address; sampled on accept.
- stop  in  1  abort an active scan.
- out  out  NOUT  registered one-hot select.
- out_valid  out  1  out holds a valid selection.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at normal scan completion.
- cur_addr  out  AW  address currently decoded.

Behaviour:
- Reset and clocking
  - One clock (clk). Reset is synchronous and active-high (rst).
  - All registers update on rising clk.
  - rst=1 at an edge gives: out=0, out_valid=0, busy=0, scan_done=0, cur_addr=0, state IDLE, dwell counter 0. This holds at any point, including mid-scan.
- Handshake
  - in_ready = (state==IDLE) && en && !rst (combinational).
  - A request is accepted when in_valid && in_ready. in_valid with in_ready low is ignored, not queued.
- States: IDLE, SCAN.
- Direct accept (mode=0), latency 1 cycle
  - in_addr < NOUT: out = 1<<in_addr, out_valid=1, cur_addr=in_addr. The output is held until the next accepted request or en=0.
  - in_addr >= NOUT: out=0, out_valid=0, cur_addr unchanged.
- Scan accept (mode=1)
  - Capture end = min(in_addr, NOUT-1) and dwell.
  - Go to SCAN. Next cycle: out=1<<0, cur_addr=0, out_valid=1, busy=1.
  - Each address is held dwell+1 cycles; dwell=0 means one cycle per address.
  - After the end address's last cycle:
    - next cycle: out=0, out_valid=0, busy=0, scan_done=1 for exactly one cycle, state IDLE;
    - in_ready returns 1 in that same cycle.
  - A new request can be accepted in the cycle scan_done is high.
- stop=1 in SCAN
  - Next cycle: out=0, out_valid=0, busy=0, state IDLE. No scan_done.
  - stop in the same cycle as the final dwell cycle: stop wins, no scan_done.
  - stop in IDLE: no effect.
- en=0
  - Next cycle: out=0, out_valid=0.
  - In SCAN: the address and dwell counters freeze and busy stays 1. When en returns, out re-asserts the frozen address next cycle and the remaining dwell continues.
  - In direct mode the selection is lost; out_valid stays 0 until a new accept.
- Width rules
  - Dwell counter is DWELLW bits; the address counter is AW bits and never exceeds end.
  - No wrap-around; end = 0 is a valid single-address scan.
- Invariant: out is zero or one-hot at all times.

Optional Feature:
- Macro: DEC_RANGE_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset 0.
  - err pulses 1 cycle after any accept with in_addr >= NOUT, in either mode.
  - A scan request with out-of-range end is rejected: state stays IDLE, no output change.
- Undefined:
  - No err port.
  - Direct out-of-range decodes to out=0 silently.
  - Scan end is clamped to NOUT-1.

Decomposition:
- Shared package dec_pkg holds:
  - state encodings ST_IDLE, ST_SCAN;
  - mode constants MODE_DIRECT=0, MODE_SCAN=1.
- Sub-module onehot_dec: combinational, parameters AW/NOUT, inputs addr and en, output one-hot.
  - Reusable by the legacy decoders.
- dec_scan_seq owns the handshake, FSM, counters and output register.

Test Plan:
1. Reset, then direct in_addr=5, en=1 → next cycle out=32'h0000_0020, out_valid=1, cur_addr=5, in_ready=1.
2. Scan, in_addr=3, dwell=1 → out 0x1, 0x2, 0x4, 0x8 for 2 cycles each, busy=1 throughout; then out=0 and scan_done=1 for one cycle.
3. Scan, end=7, dwell=0; stop asserted while cur_addr=2 → out=0 and busy=0 next cycle; scan_done stays 0.
4. Scan, end=3, dwell=3; en=0 for 3 cycles during the second cycle at addr 1 → out=0 while en=0; after en=1, addr 1 is held 2 more cycles, then addr 2.
5. NOUT=20 instance, direct in_addr=25 → out=0, out_valid=0. With DEC_RANGE_ERR_EN: err=1 for one cycle, and scan in_addr=25 leaves busy=0.
6. rst=1 mid-scan at addr 4 → next edge all outputs 0; after rst=0, in_ready=1 and a direct in_addr=0 gives out=0x1.
